// File: rtl/mux_pkg.sv
// -----------------------------------------------------------------------------
// mux_pkg
// Shared constants and helpers for the registered N:1 selector.
//   sel_width(n) : select width for an n-channel mux, max(1, clog2(n))
//   DEFAULT_*    : default channel width and channel count
//   ZERO_WORD    : word driven for an out-of-range select
// -----------------------------------------------------------------------------
package mux_pkg;

    localparam int DEFAULT_WIDTH  = 32;
    localparam int DEFAULT_NUM_IN = 7;

    localparam logic [DEFAULT_WIDTH-1:0] ZERO_WORD = '0;

    // A single-channel mux still needs a one-bit select so the port exists.
    function automatic int sel_width(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/mux_skid_stage.sv
// -----------------------------------------------------------------------------
// mux_skid_stage
// Generic WIDTH-wide valid/ready pipeline stage with a one-entry skid buffer.
// The main register drives the output; the skid register catches the one beat
// that can arrive while the output is stalled, so in_ready is a pure flop.
//   clk, rst              : clock, synchronous active-high reset
//   in_data/in_valid      : upstream beat
//   in_ready              : stage can accept (registered, = !skid_valid)
//   out_data/out_valid    : registered output beat
//   out_ready             : downstream accepts out_data
// -----------------------------------------------------------------------------
module mux_skid_stage #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             out_valid,
    input  logic             out_ready
);

    logic [WIDTH-1:0] main_data;
    logic             main_valid;
    logic [WIDTH-1:0] skid_data;
    logic             skid_valid;

    logic in_xfer;
    logic out_xfer;
    logic load_main;
    logic load_skid;

    assign in_xfer  = in_valid && in_ready;
    assign out_xfer = main_valid && out_ready;

    // Skid capture only happens when the main register is full and stalled;
    // in_ready is low whenever the skid is occupied, so a skid refill and a
    // skid drain never coincide.
    assign load_skid = in_xfer && main_valid && !out_xfer;
    assign load_main = (!main_valid || out_xfer) && (skid_valid || in_xfer);

    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge values of its neighbours regardless of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            main_data  <= '0;
            main_valid <= 1'b0;
            skid_valid <= 1'b0;
        end else begin
            if (load_main) begin
                main_data  <= skid_valid ? skid_data : in_data;
                main_valid <= 1'b1;
            end else if (out_xfer) begin
                main_valid <= 1'b0;
            end

            if (load_skid) begin
                skid_valid <= 1'b1;
            end else if (skid_valid && out_xfer) begin
                skid_valid <= 1'b0;
            end
        end
    end

    // NOTE: the skid payload is qualified by skid_valid, so it carries no reset;
    // only control state and the visible output word are reset.
    always_ff @(posedge clk) begin
        if (load_skid) begin
            skid_data <= in_data;
        end
    end

    assign in_ready  = !skid_valid;
    assign out_data  = main_data;
    assign out_valid = main_valid;

endmodule

// File: rtl/mux_n_to_1_pipe.sv
// -----------------------------------------------------------------------------
// mux_n_to_1_pipe
// Registered N:1 word selector with valid/ready handshake and skid buffer.
// An out-of-range select yields ZERO_WORD rather than stale data.
// Optional feature macro: MUX_SEL_ERR_EN
//   defined   : sticky o_sel_err set on an accepted out-of-range select,
//               cleared by i_err_clr (set wins over clear)
//   undefined : o_sel_err tied 0, i_err_clr ignored
// Ports:
//   i_clk, i_rst        : clock, synchronous active-high reset
//   i_data              : NUM_IN packed channels, channel k at [k*WIDTH +: WIDTH]
//   i_sel, i_valid      : channel index and upstream valid
//   o_ready             : block can accept a beat (registered)
//   o_data, o_valid     : registered selected word and its valid
//   i_ready             : downstream accepts o_data
//   o_sel_err, i_err_clr: sticky range error flag and its clear
// -----------------------------------------------------------------------------
module mux_n_to_1_pipe
    import mux_pkg::*;
#(
    parameter int WIDTH  = DEFAULT_WIDTH,
    parameter int NUM_IN = DEFAULT_NUM_IN,
    parameter int SEL_W  = sel_width(NUM_IN)
) (
    input  logic                    i_clk,
    input  logic                    i_rst,
    input  logic [NUM_IN*WIDTH-1:0] i_data,
    input  logic [SEL_W-1:0]        i_sel,
    input  logic                    i_valid,
    output logic                    o_ready,
    output logic [WIDTH-1:0]        o_data,
    output logic                    o_valid,
    input  logic                    i_ready,
    output logic                    o_sel_err,
    input  logic                    i_err_clr
);

    logic [WIDTH-1:0] sel_word;
    logic             sel_in_range;

    // NOTE: both outputs get a default before the loop, so no select value
    // can leave them unassigned and infer a latch.
    always_comb begin
        sel_word     = WIDTH'(ZERO_WORD);
        sel_in_range = 1'b0;
        for (int k = 0; k < NUM_IN; k++) begin
            if (i_sel == k[SEL_W-1:0]) begin
                sel_word     = i_data[k*WIDTH +: WIDTH];
                sel_in_range = 1'b1;
            end
        end
    end

    mux_skid_stage #(
        .WIDTH (WIDTH)
    ) u_stage (
        .clk       (i_clk),
        .rst       (i_rst),
        .in_data   (sel_word),
        .in_valid  (i_valid),
        .in_ready  (o_ready),
        .out_data  (o_data),
        .out_valid (o_valid),
        .out_ready (i_ready)
    );

`ifdef MUX_SEL_ERR_EN
    logic sel_err;

    // Set has priority: an offending beat accepted alongside a clear still flags.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            sel_err <= 1'b0;
        end else if (i_valid && o_ready && !sel_in_range) begin
            sel_err <= 1'b1;
        end else if (i_err_clr) begin
            sel_err <= 1'b0;
        end
    end

    assign o_sel_err = sel_err;
`else
    logic unused_err_inputs;
    assign unused_err_inputs = i_err_clr ^ sel_in_range;
    assign o_sel_err         = 1'b0;
`endif

endmodule

// File: tb/tb_mux_n_to_1_pipe.sv
// -----------------------------------------------------------------------------
// tb_mux_n_to_1_pipe
// Scoreboard bench: the driver pushes the hand-computed expected word when a
// beat is accepted; monitors pop and compare on every output transfer.
// Second instance covers the NUM_IN=1 corner.
// -----------------------------------------------------------------------------
module tb_mux_n_to_1_pipe;

`ifdef MUX_SEL_ERR_EN
    localparam logic ERR_EN = 1'b1;
`else
    localparam logic ERR_EN = 1'b0;
`endif

    localparam int W  = 32;
    localparam int N  = 7;
    localparam int SW = 3;
    localparam int W1 = 8;

    logic          i_clk = 1'b0;
    logic          i_rst;
    logic [N*W-1:0] i_data;
    logic [SW-1:0] i_sel;
    logic          i_valid;
    logic          o_ready;
    logic [W-1:0]  o_data;
    logic          o_valid;
    logic          i_ready;
    logic          o_sel_err;
    logic          i_err_clr;

    logic          u1_valid;
    logic          u1_sel;
    logic          u1_o_ready;
    logic [W1-1:0] u1_o_data;
    logic          u1_o_valid;
    logic          u1_o_sel_err;

    int total = 0;
    int bad   = 0;

    logic [W-1:0]  exp_q[$];
    logic [W1-1:0] exp1_q[$];

    always #5 i_clk = ~i_clk;

    mux_n_to_1_pipe #(.WIDTH(W), .NUM_IN(N)) dut (
        .i_clk     (i_clk),
        .i_rst     (i_rst),
        .i_data    (i_data),
        .i_sel     (i_sel),
        .i_valid   (i_valid),
        .o_ready   (o_ready),
        .o_data    (o_data),
        .o_valid   (o_valid),
        .i_ready   (i_ready),
        .o_sel_err (o_sel_err),
        .i_err_clr (i_err_clr)
    );

    mux_n_to_1_pipe #(.WIDTH(W1), .NUM_IN(1)) dut1 (
        .i_clk     (i_clk),
        .i_rst     (i_rst),
        .i_data    (8'hA5),
        .i_sel     (u1_sel),
        .i_valid   (u1_valid),
        .o_ready   (u1_o_ready),
        .o_data    (u1_o_data),
        .o_valid   (u1_o_valid),
        .i_ready   (1'b1),
        .o_sel_err (u1_o_sel_err),
        .i_err_clr (1'b0)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic cycle();
        @(posedge i_clk);
        #1;
    endtask

    // Present a beat and hold it until accepted; records the expected word.
    task automatic send(input logic [SW-1:0] sel);
        logic acc;
        int   budget;
        i_sel   = sel;
        i_valid = 1'b1;
        budget  = 0;
        acc     = 1'b0;
        while (!acc) begin
            @(negedge i_clk);
            acc = o_ready;
            if (acc) exp_q.push_back((sel < N) ? (32'h1000_0000 + 32'(sel)) : 32'h0);
            cycle();
            budget++;
            if (!acc && budget > 50) begin
                check("send_timeout", 32'(budget), 32'd0);
                acc = 1'b1;
            end
        end
    endtask

    // Monitors: an output transfer is o_valid && i_ready at the coming edge.
    initial begin
        forever begin
            @(negedge i_clk);
            if (!i_rst && o_valid && i_ready) begin
                if (exp_q.size() == 0) check("unexpected_beat", o_data, 32'hDEAD_BEEF);
                else                   check("sb_data", o_data, exp_q.pop_front());
            end
        end
    end

    initial begin
        forever begin
            @(negedge i_clk);
            if (!i_rst && u1_o_valid) begin
                if (exp1_q.size() == 0) check("u1_unexpected_beat", 32'(u1_o_data), 32'hDEAD_BEEF);
                else                    check("u1_sb_data", 32'(u1_o_data), 32'(exp1_q.pop_front()));
            end
        end
    end

    initial begin
        int budget;
        for (int k = 0; k < N; k++) i_data[k*W +: W] = 32'h1000_0000 + 32'(k);
        i_rst     = 1'b1;
        i_sel     = '0;
        i_valid   = 1'b0;
        i_ready   = 1'b1;
        i_err_clr = 1'b0;
        u1_valid  = 1'b0;
        u1_sel    = 1'b0;
        cycle();
        cycle();
        i_rst = 1'b0;
        check("rst_o_valid", 32'(o_valid), 32'd0);
        check("rst_o_data", o_data, 32'd0);
        check("rst_o_ready", 32'(o_ready), 32'd1);
        check("rst_o_sel_err", 32'(o_sel_err), 32'd0);

        // Back-to-back streaming, no backpressure.
        for (int s = 0; s < N; s++) begin
            send(SW'(s));
            check("stream_o_valid", 32'(o_valid), 32'd1);
            check("stream_o_ready", 32'(o_ready), 32'd1);
        end
        i_valid = 1'b0;
        cycle();
        check("drain_o_valid", 32'(o_valid), 32'd0);

        // Out-of-range select: zero data, sticky flag until cleared.
        send(3'd7);
        i_valid = 1'b0;
        check("oor_err_set", 32'(o_sel_err), 32'(ERR_EN));
        repeat (3) cycle();
        check("oor_err_held", 32'(o_sel_err), 32'(ERR_EN));
        i_err_clr = 1'b1;
        cycle();
        i_err_clr = 1'b0;
        check("oor_err_cleared", 32'(o_sel_err), 32'd0);

        // Backpressure: two beats buffered, third stalls, then drains in order.
        i_ready = 1'b0;
        send(3'd1);
        check("bp_ready_after_1", 32'(o_ready), 32'd1);
        send(3'd2);
        check("bp_ready_after_2", 32'(o_ready), 32'd0);
        check("bp_held_data", o_data, 32'h1000_0001);
        i_sel   = 3'd3;
        i_valid = 1'b1;
        repeat (3) begin
            @(negedge i_clk);
            check("bp_stall_ready", 32'(o_ready), 32'd0);
            check("bp_stall_data", o_data, 32'h1000_0001);
            cycle();
        end
        i_ready = 1'b1;
        send(3'd3);
        i_valid = 1'b0;
        repeat (3) cycle();
        check("bp_drained", 32'(exp_q.size()), 32'd0);

        // Reset with both registers full and the error flag set.
        i_ready = 1'b0;
        send(3'd7);
        send(3'd5);
        i_valid = 1'b0;
        check("pre_rst_ready", 32'(o_ready), 32'd0);
        check("pre_rst_err", 32'(o_sel_err), 32'(ERR_EN));
        i_rst = 1'b1;
        cycle();
        i_rst = 1'b0;
        exp_q.delete();
        check("mid_rst_o_valid", 32'(o_valid), 32'd0);
        check("mid_rst_o_data", o_data, 32'd0);
        check("mid_rst_o_ready", 32'(o_ready), 32'd1);
        check("mid_rst_o_sel_err", 32'(o_sel_err), 32'd0);
        i_ready = 1'b1;

        // Set wins over a simultaneous clear.
        i_err_clr = 1'b1;
        send(3'd7);
        i_valid   = 1'b0;
        i_err_clr = 1'b0;
        check("set_wins_err", 32'(o_sel_err), 32'(ERR_EN));
        i_err_clr = 1'b1;
        cycle();
        i_err_clr = 1'b0;
        check("set_wins_cleared", 32'(o_sel_err), 32'd0);

        // Single-channel instance.
        check("u1_ready", 32'(u1_o_ready), 32'd1);
        u1_sel   = 1'b0;
        u1_valid = 1'b1;
        exp1_q.push_back(8'hA5);
        cycle();
        check("u1_no_err", 32'(u1_o_sel_err), 32'd0);
        u1_sel = 1'b1;
        exp1_q.push_back(8'h00);
        cycle();
        u1_valid = 1'b0;
        check("u1_err", 32'(u1_o_sel_err), 32'(ERR_EN));

        budget = 0;
        while ((exp_q.size() != 0 || exp1_q.size() != 0) && budget < 20) begin
            cycle();
            budget++;
        end
        check("final_sb_empty", 32'(exp_q.size()), 32'd0);
        check("final_u1_sb_empty", 32'(exp1_q.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
